// File: rtl/hazard_pkg.sv
// Shared forwarding-select codes, FSM state type and a saturating-increment helper
// for the hazard/forwarding unit.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } hazState_t;

  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side bundle for the hazard/forwarding unit: register addresses and
// write enables in, forward selects and stall/bubble controls out.
interface hazard_forward_unit_if
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
) ();
  // No valid/ready handshake: every input is sampled each cycle and every output
  // is a same-cycle function of the inputs and the FSM state.
  logic [NUM_SRC*REG_AW-1:0] id_rs;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [NUM_SRC*REG_AW-1:0] ex_rs;
  logic [NUM_SRC-1:0]        ex_src_used;
  logic [REG_AW-1:0]         ex_rd;
  logic                      ex_memread;
  logic                      ex_mc_start;
  logic [REG_AW-1:0]         mem_rd;
  logic [REG_AW-1:0]         wb_rd;
  logic                      mem_regwrite;
  logic                      wb_regwrite;
  logic [2*NUM_SRC-1:0]      fwd_sel;
  logic                      stall_fe;
  logic                      stall_ex;
  logic                      bubble_ex;
  logic                      bubble_mem;
  logic                      mc_busy;
  hazState_t                 dbgState;

  modport master (
    output id_rs, id_src_used, ex_rs, ex_src_used, ex_rd, ex_memread, ex_mc_start,
           mem_rd, wb_rd, mem_regwrite, wb_regwrite,
    input  fwd_sel, stall_fe, stall_ex, bubble_ex, bubble_mem, mc_busy, dbgState
  );

  modport slave (
    input  id_rs, id_src_used, ex_rs, ex_src_used, ex_rd, ex_memread, ex_mc_start,
           mem_rd, wb_rd, mem_regwrite, wb_regwrite,
    output fwd_sel, stall_fe, stall_ex, bubble_ex, bubble_mem, mc_busy, dbgState
  );
endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// Forward-select for one EX source operand: EX/MEM beats MEM/WB, x0 never forwards.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              srcUsed,
  input  logic [REG_AW-1:0] memRd,
  input  logic              memRegWrite,
  input  logic [REG_AW-1:0] wbRd,
  input  logic              wbRegWrite,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_NONE;
    if (srcUsed) begin
      if (memRegWrite && (memRd != '0) && (memRd == rs)) begin
        sel = FWD_MEM;
      end else if (wbRegWrite && (wbRd != '0) && (wbRd == rs)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// EX-stage forwarding, load-use stall and multi-cycle-op stall FSM.
// Optional event counters are built when HAZ_STATS_EN is defined.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int MC_LAT  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_forward_unit_if.slave hif
`ifdef HAZ_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [31:0]          stat_ld,
  output logic [31:0]          stat_mc,
  output logic [31:0]          stat_fmem,
  output logic [31:0]          stat_fwb
`endif
);

  localparam int CNT_W = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

  hazState_t            state, stateNext;
  logic [CNT_W-1:0]     cnt, cntNext;
  logic [2*NUM_SRC-1:0] fwdSel;
  logic                 idMatch, loadHazard;
  logic                 ldStall, mcStall, busy;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_select #(.REG_AW(REG_AW)) u_fwd (
      .rs          (hif.ex_rs[g*REG_AW +: REG_AW]),
      .srcUsed     (hif.ex_src_used[g]),
      .memRd       (hif.mem_rd),
      .memRegWrite (hif.mem_regwrite),
      .wbRd        (hif.wb_rd),
      .wbRegWrite  (hif.wb_regwrite),
      .sel         (fwdSel[2*g +: 2])
    );
  end

  always_comb begin
    idMatch = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (hif.id_src_used[i] && (hif.id_rs[i*REG_AW +: REG_AW] == hif.ex_rd)) begin
        idMatch = 1'b1;
      end
    end
    loadHazard = hif.ex_memread && (hif.ex_rd != '0) && idMatch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // A multi-cycle start in IDLE takes precedence over a simultaneous load-use.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    ldStall   = 1'b0;
    mcStall   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (hif.ex_mc_start) begin
          mcStall   = 1'b1;
          cntNext   = CNT_W'(MC_LAT - 1);
          stateNext = BUSY;
        end else if (loadHazard) begin
          ldStall = 1'b1;
        end
      end
      BUSY: begin
        mcStall = 1'b1;
        busy    = 1'b1;
        cntNext = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) stateNext = RELEASE;
      end
      RELEASE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Gating with rst_n drops the stalls as soon as reset asserts, even with start held.
  assign hif.fwd_sel    = fwdSel;
  assign hif.stall_fe   = rst_n & (mcStall | ldStall);
  assign hif.stall_ex   = rst_n & mcStall;
  assign hif.bubble_mem = rst_n & mcStall;
  assign hif.bubble_ex  = rst_n & ldStall;
  assign hif.mc_busy    = rst_n & busy;
  assign hif.dbgState   = state;

`ifdef HAZ_STATS_EN
  logic anyMem, anyWb;

  always_comb begin
    anyMem = 1'b0;
    anyWb  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (fwdSel[2*i +: 2] == FWD_MEM) anyMem = 1'b1;
      if (fwdSel[2*i +: 2] == FWD_WB)  anyWb  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ld   <= '0;
      stat_mc   <= '0;
      stat_fmem <= '0;
      stat_fwb  <= '0;
    end else if (stat_clr) begin
      stat_ld   <= '0;
      stat_mc   <= '0;
      stat_fmem <= '0;
      stat_fwb  <= '0;
    end else begin
      if (ldStall) stat_ld   <= satInc(stat_ld);
      if (mcStall) stat_mc   <= satInc(stat_mc);
      if (anyMem)  stat_fmem <= satInc(stat_fmem);
      if (anyWb)   stat_fwb  <= satInc(stat_fwb);
    end
  end
`endif

endmodule
